// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-read/multi-write RAM.
package ram_pkg;

  // Clear-engine FSM states.
  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  // Width needed to count 0..value-1; never returns less than 1.
  function automatic int unsigned clog2_safe(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/ram_wr_arbiter.sv
// Write-port arbiter: highest-numbered enabled port wins an address; flags any
// pair of enabled ports aiming at the same address.
module ram_wr_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned WPORT = 2,
  parameter int unsigned INDEX = 4
) (
  input  logic [WPORT*INDEX-1:0] addr,
  input  logic [WPORT-1:0]       we,
  output logic [WPORT-1:0]       wins,
  output logic                   collision
);

  // A port loses whenever any higher-numbered enabled port shares its address.
  always_comb begin
    wins      = we;
    collision = 1'b0;
    for (int unsigned a = 0; a < WPORT; a++) begin
      for (int unsigned b = a + 1; b < WPORT; b++) begin
        if (we[a] && we[b] && (addr[a*INDEX +: INDEX] == addr[b*INDEX +: INDEX])) begin
          wins[a]   = 1'b0;
          collision = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_mrmw_init.sv
// Parametrised multi-read/multi-write register-file RAM with a sequential
// clear engine (CLR_PER_CYC entries per cycle) re-armed by reset or flush.
// Optional feature macro: RAM_WR_BYPASS_EN (same-cycle write-to-read forwarding).
module ram_mrmw_init
  import ram_pkg::*;
#(
  parameter int unsigned    RPORT       = 2,
  parameter int unsigned    WPORT       = 2,
  parameter int unsigned    DEPTH       = 16,
  parameter int unsigned    INDEX       = 4,
  parameter int unsigned    WIDTH       = 8,
  parameter int unsigned    CLR_PER_CYC = 4,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RPORT*INDEX-1:0] addr_i,
  output logic [RPORT*WIDTH-1:0] data_o,
  input  logic [WPORT*INDEX-1:0] addrwr_i,
  input  logic [WPORT*WIDTH-1:0] datawr_i,
  input  logic [WPORT-1:0]       we_i,
  input  logic                   flush_i,
  output logic                   ready_o,
  output logic                   collision_o
);

  localparam int unsigned       NGRP     = DEPTH / CLR_PER_CYC;
  localparam int unsigned       CW       = clog2_safe(NGRP);
  localparam logic [CW-1:0]     LAST_GRP = CW'(NGRP - 1);
  localparam logic [INDEX:0]    DEPTH_L  = (INDEX + 1)'(DEPTH);

  ram_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             coll_q;
  logic [WIDTH-1:0] ram_q [DEPTH];

  logic             accept;
  logic [WPORT-1:0] we_acc;
  logic [WPORT-1:0] wins;
  logic             coll;
  logic [INDEX-1:0] ra;
  logic [INDEX-1:0] wa;

  // Writes only count while the array is initialised and no flush is pending.
  assign accept = (state_q == RAM_READY) && !flush_i;
  assign we_acc = accept ? we_i : '0;

  ram_wr_arbiter #(
    .WPORT (WPORT),
    .INDEX (INDEX)
  ) u_arb (
    .addr      (addrwr_i),
    .we        (we_acc),
    .wins      (wins),
    .collision (coll)
  );

  // Clear-engine FSM with registered ready and collision outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RAM_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      coll_q <= coll;
      unique case (state_q)
        RAM_CLEAR: begin
          if (flush_i) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_GRP) begin
            state_q <= RAM_READY;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RAM_READY: begin
          if (flush_i) begin
            state_q <= RAM_CLEAR;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= RAM_CLEAR;
          ready_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Array storage: clear one group per cycle while clearing, else commit winning writes.
  always_ff @(posedge clk) begin
    if (state_q == RAM_CLEAR) begin
      for (int unsigned k = 0; k < CLR_PER_CYC; k++) begin
        ram_q[INDEX'(32'(cnt_q) * CLR_PER_CYC + k)] <= INIT_VAL;
      end
    end else begin
      for (int unsigned w = 0; w < WPORT; w++) begin
        if (wins[w] && ({1'b0, addrwr_i[w*INDEX +: INDEX]} < DEPTH_L)) begin
          ram_q[addrwr_i[w*INDEX +: INDEX]] <= datawr_i[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Combinational read ports; out-of-range addresses read as zero.
  always_comb begin
    data_o = '0;
    ra     = '0;
    wa     = '0;
    for (int unsigned r = 0; r < RPORT; r++) begin
      ra = addr_i[r*INDEX +: INDEX];
      if ({1'b0, ra} < DEPTH_L) begin
        data_o[r*WIDTH +: WIDTH] = ram_q[ra];
`ifdef RAM_WR_BYPASS_EN
        // At most one port wins a given address, so scan order is irrelevant.
        for (int unsigned w = 0; w < WPORT; w++) begin
          wa = addrwr_i[w*INDEX +: INDEX];
          if (wins[w] && (wa == ra)) begin
            data_o[r*WIDTH +: WIDTH] = datawr_i[w*WIDTH +: WIDTH];
          end
        end
`endif
      end
    end
  end

  assign ready_o     = ready_q;
  assign collision_o = coll_q;

endmodule

// File: tb/tb_ram_mrmw_init.sv
// Self-checking bench for ram_mrmw_init (default parameters).
module tb_ram_mrmw_init;

  localparam int RP    = 2;
  localparam int WP    = 2;
  localparam int DEPTH = 16;
  localparam int NGRP  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   addr_i = '0;
  logic [15:0]  data_o;
  logic [7:0]   addrwr_i = '0;
  logic [15:0]  datawr_i = '0;
  logic [1:0]   we_i = '0;
  logic         flush_i = 1'b0;
  logic         ready_o;
  logic         collision_o;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: contents, readiness, cycles of clearing left, collision flag.
  logic [7:0] m_mem [DEPTH];
  bit         m_ready;
  int         m_left;
  bit         m_coll;

  typedef struct {
    logic [3:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic [1:0] we;
    logic [3:0] ra0, ra1;
    logic [7:0] er0, er1;
    logic       ecoll;
  } vec_t;
  vec_t vt [5];

  ram_mrmw_init dut (
    .clk         (clk),
    .reset       (reset),
    .addr_i      (addr_i),
    .data_o      (data_o),
    .addrwr_i    (addrwr_i),
    .datawr_i    (datawr_i),
    .we_i        (we_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .collision_o (collision_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] expect_read(input int a);
    logic [7:0] v;
    if (a >= DEPTH) return 8'h00;
    v = m_mem[a];
`ifdef RAM_WR_BYPASS_EN
    if (m_ready && !flush_i)
      for (int w = 0; w < WP; w++)
        if (we_i[w] && int'(addrwr_i[w*4 +: 4]) == a) v = datawr_i[w*8 +: 8];
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_ready = 0;
    m_left  = NGRP;
    m_coll  = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at the edge.
  task automatic model_edge();
    bit c;
    c = 0;
    if (reset) return;
    if (m_ready && !flush_i) begin
      for (int w = 0; w < WP; w++)
        if (we_i[w] && int'(addrwr_i[w*4 +: 4]) < DEPTH)
          m_mem[addrwr_i[w*4 +: 4]] = datawr_i[w*8 +: 8];
      for (int a = 0; a < WP; a++)
        for (int b = a + 1; b < WP; b++)
          if (we_i[a] && we_i[b] && addrwr_i[a*4 +: 4] == addrwr_i[b*4 +: 4]) c = 1;
    end
    m_coll = c;
    if (flush_i) begin
      m_ready = 0;
      m_left  = NGRP;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      end
    end
  endtask

  task automatic check_outputs();
    check("ready", 32'(ready_o), 32'(m_ready));
    check("collision", 32'(collision_o), 32'(m_coll));
    if (m_ready)
      for (int r = 0; r < RP; r++)
        check($sformatf("read%0d@%0d", r, addr_i[r*4 +: 4]), 32'(data_o[r*8 +: 8]),
              32'(expect_read(int'(addr_i[r*4 +: 4]))));
  endtask

  // Called at a negedge with inputs set: check, cross one rising edge, return at next negedge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we_i    = '0;
    flush_i = 1'b0;
  endtask

  // Count cycles until ready_o rises, bounded.
  task automatic wait_ready(input string name, input int exp_cycles);
    int count;
    count = 0;
    while (!ready_o && count < 10) begin
      tick();
      count++;
    end
    check(name, 32'(count), 32'(exp_cycles));
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < DEPTH / 2; i++) begin
      addr_i = {4'(2 * i + 1), 4'(2 * i)};
      #1;
      check($sformatf("%s_lo%0d", name, 2 * i), 32'(data_o[7:0]), 32'h0);
      check($sformatf("%s_hi%0d", name, 2 * i + 1), 32'(data_o[15:8]), 32'h0);
      tick();
    end
  endtask

  initial begin
    vt[0] = '{wa0: 4'd3, wa1: 4'd5, wd0: 8'hAA, wd1: 8'h55, we: 2'b11,
              ra0: 4'd3, ra1: 4'd5, er0: 8'hAA, er1: 8'h55, ecoll: 1'b0};
    vt[1] = '{wa0: 4'd7, wa1: 4'd7, wd0: 8'h11, wd1: 8'h22, we: 2'b11,
              ra0: 4'd7, ra1: 4'd3, er0: 8'h22, er1: 8'hAA, ecoll: 1'b1};
    vt[2] = '{wa0: 4'd7, wa1: 4'd7, wd0: 8'h99, wd1: 8'h98, we: 2'b00,
              ra0: 4'd7, ra1: 4'd5, er0: 8'h22, er1: 8'h55, ecoll: 1'b0};
    vt[3] = '{wa0: 4'd15, wa1: 4'd15, wd0: 8'h0F, wd1: 8'hF0, we: 2'b10,
              ra0: 4'd15, ra1: 4'd7, er0: 8'hF0, er1: 8'h22, ecoll: 1'b0};
    vt[4] = '{wa0: 4'd9, wa1: 4'd9, wd0: 8'h01, wd1: 8'h02, we: 2'b01,
              ra0: 4'd9, ra1: 4'd15, er0: 8'h01, er1: 8'hF0, ecoll: 1'b0};

    // Reset and initial clear.
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hXX;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_coll", 32'(collision_o), 32'h0);
    reset = 1'b0;
    wait_ready("clear_len", NGRP);
    check_all_zero("init");

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      addrwr_i = {vt[i].wa1, vt[i].wa0};
      datawr_i = {vt[i].wd1, vt[i].wd0};
      we_i     = vt[i].we;
      tick();
      we_i   = '0;
      addr_i = {vt[i].ra1, vt[i].ra0};
      #1;
      check($sformatf("tbl%0d_rd0", i), 32'(data_o[7:0]), 32'(vt[i].er0));
      check($sformatf("tbl%0d_rd1", i), 32'(data_o[15:8]), 32'(vt[i].er1));
      check($sformatf("tbl%0d_coll", i), 32'(collision_o), 32'(vt[i].ecoll));
      tick();
    end

    // Same-cycle read of an address being written.
    addr_i   = {4'd0, 4'd9};
    addrwr_i = {4'd0, 4'd9};
    datawr_i = {8'h00, 8'h7E};
    we_i     = 2'b01;
    #1;
`ifdef RAM_WR_BYPASS_EN
    check("bypass_same", 32'(data_o[7:0]), 32'h7E);
`else
    check("bypass_same", 32'(data_o[7:0]), 32'h01);
`endif
    tick();
    we_i = '0;
    #1;
    check("bypass_next", 32'(data_o[7:0]), 32'h7E);
    tick();

    // Flush with a simultaneous write: write dropped, full re-clear.
    addrwr_i = {4'd0, 4'd2};
    datawr_i = {8'h00, 8'h33};
    we_i     = 2'b01;
    flush_i  = 1'b1;
    tick();
    idle();
    #1;
    check("flush_ready_fall", 32'(ready_o), 32'h0);
    wait_ready("flush_len", NGRP);
    check_all_zero("flush");

    // Async reset two cycles into a clear.
    flush_i = 1'b1;
    tick();
    idle();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_midclear_ready", 32'(ready_o), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wait_ready("rst_midclear_len", NGRP);

    // Async reset while ready: output drops with no clock edge.
    addrwr_i = {4'd4, 4'd6};
    datawr_i = {8'h44, 8'h66};
    we_i     = 2'b11;
    tick();
    idle();
    #2 reset = 1'b1;
    #1;
    check("rst_ready_async", 32'(ready_o), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wait_ready("rst_ready_len", NGRP);
    check_all_zero("rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      addr_i   = 8'($urandom);
      addrwr_i = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      datawr_i = 16'($urandom);
      we_i     = 2'($urandom);
      flush_i  = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
